single_port_ram: RTL and testbench

Single-port 1024 x 8 synchronous-write, asynchronous-read memory for general-purpose on-chip scratch storage. One shared address bus serves both reads and writes. A synchronous active-high reset clears every location to zero. Reads are combinational from the address, so a value is valid at `data_out` within the same cycle the address is presented.

---
 rtl/single_port_ram.sv | 48 ++++
 tb/tb_single_port_ram.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/single_port_ram.sv
// single_port_ram
//   1024 x 8 (by default) scratch memory with one shared address bus.
//   Writes are synchronous; reads are combinational from the address.
//   A synchronous active-high reset clears every word in one cycle, so the
//   storage is a flop array rather than an inferred block RAM.
//
// Parameters:
//   ADDR_W  address width in bits
//   DATA_W  word width in bits
//   DEPTH   number of words; must equal 2**ADDR_W
//
// Ports:
//   clk       rising-edge clock for all state changes
//   rst       synchronous active-high reset, clears all words, beats wr
//   wr        write enable, level-sensitive, one write per edge
//   addr      word address shared by reads and writes
//   data_in   write data
//   data_out  mem[addr], combinational, no read enable, no output register
module single_port_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset has priority: a write presented on the reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (wr) begin
      mem[addr] <= data_in;
    end
  end

  // No bypass: during a write cycle the old word is visible until the edge.
  always_comb begin
    data_out = mem[addr];
  end

endmodule

// File: tb/tb_single_port_ram.sv
// tb_single_port_ram
//   Directed self-checking bench for single_port_ram. Inputs change on the
//   falling edge; data_out is sampled between edges.
module tb_single_port_ram;

  logic       clk;
  logic       rst;
  logic       wr;
  logic [9:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int tests;
  int fails;

  single_port_ram #(
    .ADDR_W(10),
    .DATA_W(8),
    .DEPTH (1024)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One write: drive on the falling edge, commit on the next rising edge.
  task automatic do_write(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    wr      = 1'b1;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [9:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, data_out, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] a;
    logic [7:0] e;
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    wr      = 1'b0;
    addr    = '0;
    data_in = '0;

    // Reset state.
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_read("reset_addr000", 10'h000, 8'h00);
    do_read("reset_addr3ff", 10'h3FF, 8'h00);
    do_read("reset_addr155", 10'h155, 8'h00);

    // Basic write/read across the 0xFF/0x100 boundary.
    do_write(10'h0FF, 8'hEC);
    do_write(10'h100, 8'hEB);
    do_read("basic_0ff", 10'h0FF, 8'hEC);
    do_read("basic_100", 10'h100, 8'hEB);
    do_read("basic_0fe", 10'h0FE, 8'h00);
    do_read("basic_1ff", 10'h1FF, 8'h00);

    // Reset clear.
    do_write(10'h000, 8'h5A);
    do_write(10'h3FF, 8'hA5);
    do_read("pre_clear_000", 10'h000, 8'h5A);
    do_read("pre_clear_3ff", 10'h3FF, 8'hA5);
    pulse_reset();
    do_read("clear_000", 10'h000, 8'h00);
    do_read("clear_3ff", 10'h3FF, 8'h00);
    do_read("clear_0ff", 10'h0FF, 8'h00);

    // Write ignored during reset.
    @(negedge clk);
    rst     = 1'b1;
    wr      = 1'b1;
    addr    = 10'h010;
    data_in = 8'h77;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr  = 1'b0;
    do_read("wr_during_rst_010", 10'h010, 8'h00);

    // Idle hold: one address per cycle with wr low.
    do_write(10'h200, 8'h3C);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      a = 10'(i);
      e = (a == 10'h200) ? 8'h3C : 8'h00;
      do_read("idle_sweep", a, e);
    end

    // Overwrite and read-during-write.
    do_write(10'h155, 8'h11);
    do_read("ovw_first", 10'h155, 8'h11);
    @(negedge clk);
    wr      = 1'b1;
    addr    = 10'h155;
    data_in = 8'h22;
    #1;
    check("rdw_old_word", data_out, 8'h11);
    @(posedge clk);
    #1;
    check("rdw_new_word", data_out, 8'h22);
    wr = 1'b0;

    // Full sweep with wr held high across edges (level-sensitive writes).
    @(negedge clk);
    wr = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      a       = 10'(i);
      addr    = a;
      data_in = a[7:0] ^ {6'b0, a[9:8]};
      @(negedge clk);
    end
    wr = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      a = 10'(i);
      e = a[7:0] ^ {6'b0, a[9:8]};
      do_read("full_sweep", a, e);
    end

    // Reset mid-operation after the sweep: everything back to zero.
    pulse_reset();
    do_read("post_sweep_rst_155", 10'h155, 8'h00);
    do_read("post_sweep_rst_2ab", 10'h2AB, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
